// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex codes from a multiplexed, active-low 7-segment scan bus.
// Optional build macro SEG_SCAN_DECODER_STALE_EN: per-digit capture expiry after STALE_CYCLES.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] code,
  output logic [3:0]  dp,
  output logic [3:0]  valid,
  output logic [3:0]  blank,
  output logic [3:0]  unknown,
  output logic        upd
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || STALE_CYCLES < 1) begin : g_param_check
    $error("seg_scan_decoder: STABLE_CYCLES must be 2..255 and STALE_CYCLES >= 1");
  end

  // Returns {hit, nibble}; nibble is 0 when the pattern is not a hex glyph.
  function automatic logic [4:0] f_glyph(input logic [6:0] g);
    case (g)
      7'h40:   f_glyph = {1'b1, 4'h0};
      7'h79:   f_glyph = {1'b1, 4'h1};
      7'h24:   f_glyph = {1'b1, 4'h2};
      7'h30:   f_glyph = {1'b1, 4'h3};
      7'h19:   f_glyph = {1'b1, 4'h4};
      7'h12:   f_glyph = {1'b1, 4'h5};
      7'h02:   f_glyph = {1'b1, 4'h6};
      7'h78:   f_glyph = {1'b1, 4'h7};
      7'h00:   f_glyph = {1'b1, 4'h8};
      7'h10:   f_glyph = {1'b1, 4'h9};
      7'h08:   f_glyph = {1'b1, 4'hA};
      7'h03:   f_glyph = {1'b1, 4'hB};
      7'h27:   f_glyph = {1'b1, 4'hC};
      7'h21:   f_glyph = {1'b1, 4'hD};
      7'h06:   f_glyph = {1'b1, 4'hE};
      7'h0E:   f_glyph = {1'b1, 4'hF};
      default: f_glyph = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [7:0] f_sat_inc(input logic [7:0] c);
    f_sat_inc = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]  r_an_p0, r_an_p1;
  logic [7:0]  r_seg_p0, r_seg_p1;
  logic [15:0] r_code;
  logic [3:0]  r_dp, r_valid, r_blank, r_unknown;
  logic        r_upd;
  logic        w_commit, w_same, w_idle, w_blank, w_unknown;
  logic [4:0]  w_glyph;

  assign w_same    = ({r_an_p0, r_seg_p0} == {r_an_p1, r_seg_p1});
  assign w_idle    = &r_an_p0;
  assign w_cnt_inc = f_sat_inc(r_cnt);
  assign w_glyph   = f_glyph(r_seg_p0[6:0]);
  assign w_blank   = (r_seg_p0[6:0] == 7'h7F);
  assign w_unknown = !w_glyph[4] && !w_blank;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 8'd0;
        if (!w_idle) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = 8'd1;
        end
      end
      SETTLE: begin
        if (w_same) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= STABLE_N) begin
            w_commit    = 1'b1;
            w_state_nxt = HELD;
          end
        end else if (w_idle) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = 8'd1;
        end
      end
      HELD: begin
        if (!w_same) begin
          w_state_nxt = w_idle ? IDLE : SETTLE;
          w_cnt_nxt   = w_idle ? 8'd0 : 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

`ifdef SEG_SCAN_DECODER_STALE_EN
  localparam int TW = $clog2(STALE_CYCLES + 1);
  localparam logic [TW-1:0] STALE_MAX  = TW'(STALE_CYCLES);
  localparam logic [TW-1:0] STALE_LAST = TW'(STALE_CYCLES - 1);
  logic [TW-1:0] r_timer [4];
`endif

  // p0 holds the current sample S, p1 the sample before it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_an_p0   <= 4'hF;
      r_seg_p0  <= 8'hFF;
      r_an_p1   <= 4'hF;
      r_seg_p1  <= 8'hFF;
      r_code    <= 16'h0000;
      r_dp      <= 4'h0;
      r_valid   <= 4'h0;
      r_blank   <= 4'h0;
      r_unknown <= 4'h0;
      r_upd     <= 1'b0;
`ifdef SEG_SCAN_DECODER_STALE_EN
      for (int i = 0; i < 4; i++) r_timer[i] <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_an_p0  <= an;
      r_seg_p0 <= seg;
      r_an_p1  <= r_an_p0;
      r_seg_p1 <= r_seg_p0;
      r_upd    <= w_commit;
      for (int i = 0; i < 4; i++) begin
        if (w_commit && !r_an_p0[i]) begin
          r_code[4*i +: 4] <= w_glyph[3:0];
          r_dp[i]          <= ~r_seg_p0[7];
          r_valid[i]       <= 1'b1;
          r_blank[i]       <= w_blank;
          r_unknown[i]     <= w_unknown;
`ifdef SEG_SCAN_DECODER_STALE_EN
          r_timer[i]       <= '0;
        end else begin
          if (r_timer[i] != STALE_MAX) r_timer[i] <= r_timer[i] + TW'(1);
          // Expiry keeps code and dp so the last reading stays inspectable
          if (r_timer[i] == STALE_LAST) begin
            r_valid[i]   <= 1'b0;
            r_blank[i]   <= 1'b0;
            r_unknown[i] <= 1'b0;
          end
`endif
        end
      end
    end
  end

  assign code    = r_code;
  assign dp      = r_dp;
  assign valid   = r_valid;
  assign blank   = r_blank;
  assign unknown = r_unknown;
  assign upd     = r_upd;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed vectors, glyph table and random runs
// checked cycle-by-cycle against a run-length reference model.
module tb_seg_scan_decoder;
  localparam int STABLE = 16;
  localparam int STALE  = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] code;
  logic [3:0]  dp, valid, blank, unknown;
  logic        upd;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .code(code), .dp(dp),
    .valid(valid), .blank(blank), .unknown(unknown), .upd(upd)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: a commit happens when the current sample has been seen exactly
  // STABLE times in a row and lights at least one anode.
  logic [6:0]  gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
  logic [11:0] m_s = 12'hFFF;
  int          m_run = 1;
  logic [15:0] m_code = '0;
  logic [3:0]  m_dp = '0, m_valid = '0, m_blank = '0, m_unk = '0;
  logic        m_upd = 1'b0;
`ifdef SEG_SCAN_DECODER_STALE_EN
  int          m_age [4] = '{0, 0, 0, 0};
`endif

  task automatic model_edge(input logic rb, input logic [3:0] a, input logic [7:0] sg);
    int   nib;
    logic hit;
    if (!rb) begin
      m_s = 12'hFFF; m_run = 1;
      m_code = '0; m_dp = '0; m_valid = '0; m_blank = '0; m_unk = '0; m_upd = 1'b0;
`ifdef SEG_SCAN_DECODER_STALE_EN
      for (int i = 0; i < 4; i++) m_age[i] = 0;
`endif
    end else begin
      m_upd = (m_run == STABLE) && (m_s[11:8] != 4'hF);
      hit = 1'b0; nib = 0;
      for (int k = 0; k < 16; k++) if (gly[k] == m_s[6:0]) begin hit = 1'b1; nib = k; end
      for (int i = 0; i < 4; i++) begin
        if (m_upd && !m_s[8+i]) begin
          m_code[4*i +: 4] = 4'(nib);
          m_dp[i]    = ~m_s[7];
          m_valid[i] = 1'b1;
          m_blank[i] = (m_s[6:0] == 7'h7F);
          m_unk[i]   = !hit && (m_s[6:0] != 7'h7F);
`ifdef SEG_SCAN_DECODER_STALE_EN
          m_age[i]   = 0;
        end else begin
          if (m_age[i] < STALE) m_age[i]++;
          if (m_age[i] == STALE) begin m_valid[i] = 1'b0; m_blank[i] = 1'b0; m_unk[i] = 1'b0; end
`endif
        end
      end
      if ({a, sg} == m_s) begin
        if (m_run < 100000) m_run++;
      end else m_run = 1;
      m_s = {a, sg};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst_n, an, seg);
    #1;
    check("model", 64'({code, dp, valid, blank, unknown, upd}),
                   64'({m_code, m_dp, m_valid, m_blank, m_unk, m_upd}));
  endtask

  task automatic ticks_to_upd(input int limit, output int k);
    k = -1;
    for (int j = 1; j <= limit; j++) begin
      tick();
      if (upd === 1'b1) begin k = j; break; end
    end
  endtask

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] nib;
    logic       dpx;
    logic       bl;
    logic       un;
  } vec_t;

  vec_t vt [20];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, kc, n_upd, d;
    logic [15:0] sc;
    logic [3:0]  sd;

    vt[0]  = '{4'b1110, 8'hC0, 4'h0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{4'b1101, 8'h79, 4'h1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{4'b1011, 8'hA4, 4'h2, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{4'b0111, 8'h30, 4'h3, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{4'b1110, 8'h99, 4'h4, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{4'b1101, 8'h12, 4'h5, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{4'b1011, 8'h82, 4'h6, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{4'b0111, 8'h78, 4'h7, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{4'b1110, 8'h80, 4'h8, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{4'b1101, 8'h10, 4'h9, 1'b1, 1'b0, 1'b0};
    vt[10] = '{4'b1011, 8'h88, 4'hA, 1'b0, 1'b0, 1'b0};
    vt[11] = '{4'b0111, 8'h03, 4'hB, 1'b1, 1'b0, 1'b0};
    vt[12] = '{4'b1110, 8'hA7, 4'hC, 1'b0, 1'b0, 1'b0};
    vt[13] = '{4'b1101, 8'h21, 4'hD, 1'b1, 1'b0, 1'b0};
    vt[14] = '{4'b1011, 8'h86, 4'hE, 1'b0, 1'b0, 1'b0};
    vt[15] = '{4'b0111, 8'h0E, 4'hF, 1'b1, 1'b0, 1'b0};
    vt[16] = '{4'b1110, 8'hFF, 4'h0, 1'b0, 1'b1, 1'b0};
    vt[17] = '{4'b1101, 8'h7F, 4'h0, 1'b1, 1'b1, 1'b0};
    vt[18] = '{4'b1011, 8'hD5, 4'h0, 1'b0, 1'b0, 1'b1};
    vt[19] = '{4'b0111, 8'h3F, 4'h0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; an = 4'hF; seg = 8'hFF;
    repeat (2) tick();
    check("reset_outputs", 64'({code, dp, valid, blank, unknown, upd}), 64'(0));

    // Digit 0 shows '0' with dp off: upd 17 edges after the sample register takes it
    rst_n = 1'b1; an = 4'b1110; seg = 8'hC0;
    ticks_to_upd(20, k);
    check("first_upd_latency", 64'(k), 64'(17));
    n_upd = 0;
    repeat (3) begin tick(); n_upd += int'(upd); end
    check("single_upd", 64'(n_upd), 64'(0));
    check("d0_fields", 64'({code[3:0], valid, dp, blank, unknown}), 64'({4'h0, 4'b0001, 4'b0000, 8'h00}));

    // Two anodes at once: digits 0 and 3 load 'E' with dp, digit 1 keeps its '5'
    an = 4'b1101; seg = 8'h92;
    ticks_to_upd(20, k);
    check("d1_latency", 64'(k), 64'(17));
    an = 4'b0110; seg = 8'h06;
    ticks_to_upd(20, k);
    check("dual_latency", 64'(k), 64'(17));
    check("dual_code", 64'(code), 64'(16'hE05E));
    check("dual_dp_valid", 64'({dp, valid}), 64'({4'b1001, 4'b1011}));

    // Segments toggling faster than the stability window never commit
    sc = code; sd = dp; n_upd = 0;
    an = 4'b1011;
    for (int p = 0; p < 6; p++) begin
      seg = p[0] ? 8'hA4 : 8'hF9;
      repeat (10) begin tick(); n_upd += int'(upd); end
    end
    check("toggle_no_upd", 64'(n_upd), 64'(0));
    check("toggle_hold", 64'({code, dp}), 64'({sc, sd}));
    seg = 8'hFF;
    ticks_to_upd(20, k);
    check("blank_latency", 64'(k), 64'(17));
    check("blank_d2", 64'({code[11:8], valid[2], blank[2], unknown[2]}), 64'({4'h0, 3'b110}));
    seg = 8'hCF;
    ticks_to_upd(20, k);
    check("unknown_latency", 64'(k), 64'(17));
    check("unknown_d2", 64'({code[11:8], valid[2], blank[2], unknown[2]}), 64'({4'h0, 3'b101}));

    // A change on the edge that would complete the window restarts the count
    an = 4'b0111; seg = 8'h99; n_upd = 0;
    repeat (15) begin tick(); n_upd += int'(upd); end
    seg = 8'h92;
    ticks_to_upd(25, k);
    check("late_change_no_upd", 64'(n_upd), 64'(0));
    check("late_change_latency", 64'(k), 64'(17));
    check("late_change_code", 64'(code[15:12]), 64'(4'h5));

    // Reset at count 15 drops the pending capture; a full new window is required
    an = 4'b1101; seg = 8'hA4; n_upd = 0;
    repeat (16) begin tick(); n_upd += int'(upd); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks_to_upd(25, k);
    check("pre_reset_no_upd", 64'(n_upd), 64'(0));
    check("post_reset_latency", 64'(k), 64'(17));
    check("post_reset_fields", 64'({code, valid}), 64'({16'h0020, 4'b0010}));

    // Glyph table, one digit at a time
    for (int i = 0; i < 20; i++) begin
      an = vt[i].an; seg = vt[i].seg; n_upd = 0; d = 0;
      for (int j = 0; j < 4; j++) if (!vt[i].an[j]) d = j;
      repeat (16) begin tick(); n_upd += int'(upd); end
      tick();
      check("tbl_upd", 64'({n_upd[3:0], upd}), 64'({4'h0, 1'b1}));
      check("tbl_fields", 64'({code[4*d +: 4], dp[d], valid[d], blank[d], unknown[d]}),
                          64'({vt[i].nib, vt[i].dpx, 1'b1, vt[i].bl, vt[i].un}));
    end

    // Capture expiry on digit 1 once the bus goes idle
    an = 4'b1101; seg = 8'h30;
    ticks_to_upd(20, k);
    check("stale_capture", 64'(k), 64'(17));
    an = 4'hF; seg = 8'hFF; kc = -1;
    for (int j = 1; j <= 130; j++) begin
      tick();
      if (valid[1] === 1'b0 && kc < 0) kc = j;
    end
`ifdef SEG_SCAN_DECODER_STALE_EN
    check("stale_clear_cycle", 64'(kc), 64'(STALE));
`else
    check("no_stale_valid", 64'(valid[1]), 64'(1));
`endif
    check("stale_code_kept", 64'({code[7:4], dp[1]}), 64'({4'h3, 1'b1}));

    // Randomized segments, checked by the model on every cycle
    for (int r = 0; r < 90; r++) begin
      case ($urandom_range(0, 4))
        0:       an = 4'hF;
        1:       an = 4'($urandom_range(0, 15));
        default: an = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       seg = 8'($urandom_range(0, 255));
        1:       seg = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 7'h7F};
        default: seg = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, gly[$urandom_range(0, 15)]};
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 24)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples required before a capture; legal range 2..255.
REQ-002 SHALL have parameter STALE_CYCLES, default 2000000: idle cycles after which a digit's capture expires (20 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1, 100 MHz system clock, rising edge only.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port an, input, 4, anode lines, active low; bit0 is the rightmost digit.
REQ-006 SHALL have port seg, input, 8, cathode lines, active low; seg[7] is dp and seg[6:0] is g..a.
REQ-007 SHALL have port code, output, 16, decoded nibble per digit; digit i occupies bits 4i+3:4i.
REQ-008 SHALL have port dp, output, 4, decimal point lit, one bit per digit.
REQ-009 SHALL have port valid, output, 4, digit holds a live capture.
REQ-010 SHALL have port blank, output, 4, last capture had all segments off.
REQ-011 SHALL have port unknown, output, 4, last capture was not a hex glyph and not blank.
REQ-012 SHALL have port upd, output, 1, single-cycle pulse on any commit.

Function
REQ-013 SHALL register {an,seg} each cycle into sample S; all decisions use S, never the raw inputs.
REQ-014 SHALL run FSM states IDLE, SETTLE, HELD.
- IDLE: an==4'b1111. Any anode low goes to SETTLE with the counter at 1.
- SETTLE: S equal to the previous S increments the counter. Any change restarts the count at 1, or returns to IDLE if an==4'b1111.
- Counter reaching STABLE_CYCLES commits and moves to HELD.
- HELD: no re-commit while S is unchanged. A change goes to SETTLE with the counter at 1, or to IDLE.
REQ-015 On commit, every digit i with S.an[i]==0 SHALL load the glyph. This includes multiple simultaneous active anodes, e.g. an=4'b0110 loads digits 0 and 3.
REQ-016 Glyph map on seg[6:0] (hex): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 27→C, 21→d, 06→E, 0E→F.
REQ-017 For a committed digit, flags SHALL be set as follows:
- Mapped glyph: code=nibble, valid=1, blank=0, unknown=0.
- seg[6:0]==7F: code=0, valid=1, blank=1, unknown=0.
- Any other pattern: code=0, valid=1, blank=0, unknown=1.
- In all three cases dp=~seg[7].
REQ-018 Digits not active at commit SHALL retain all their fields.
REQ-019 Outputs for a commit SHALL appear on the edge after the cycle the counter reaches STABLE_CYCLES. Latency from a stable input change is STABLE_CYCLES+1 cycles, with upd high for exactly that one cycle.
REQ-020 A change on the same cycle the counter would reach STABLE_CYCLES SHALL suppress the commit and restart the count.
REQ-021 The counter SHALL saturate and never wrap.
REQ-022 The FSM SHALL never leave an illegal state; an unreachable encoding SHALL return to IDLE.

Reset
REQ-023 While rst_n==0 at a rising edge, the block SHALL load:
- code=0, dp=0, valid=0, blank=0, unknown=0, upd=0.
- FSM=IDLE, counter=0, S={4'hF,8'hFF}, all stale timers 0.
REQ-024 Reset asserted mid-SETTLE or mid-HELD SHALL discard the pending capture; no upd SHALL follow reset release without a fresh STABLE_CYCLES window.

Configuration
REQ-025 Macro SEG_SCAN_DECODER_STALE_EN defined: each digit SHALL have a timer that clears on that digit's commit and otherwise increments (saturating). On reaching STALE_CYCLES the digit SHALL clear valid, blank and unknown, leave code and dp unchanged, and not pulse upd.
REQ-026 Macro undefined: no stale timers SHALL be built, and valid SHALL stay set until reset.

Verification
REQ-027 Reset, then an=1110, seg=8'hC0 held 20 cycles -> upd once at cycle 17, code[3:0]=0, valid=0001, dp=0000.
REQ-028 an=0110, seg=8'h06 stable -> digits 0 and 3 code=E, dp=1001, valid=1001; digits 1 and 2 unchanged.
REQ-029 seg toggles every 10 cycles with STABLE_CYCLES=16 -> no upd, outputs unchanged; then seg=8'hFF held -> blank set on active digit; seg=8'hCF -> unknown set.
REQ-030 rst_n pulled low at count 15 of a window, released -> no upd until 16 further stable cycles.
REQ-031 With SEG_SCAN_DECODER_STALE_EN and STALE_CYCLES=100: capture digit 1 then an=1111 -> valid[1] clears exactly 100 cycles after commit, code kept. Without the macro -> valid[1] stays 1.
